rr_onehot_arbiter: RTL and testbench
====================================

// Module: rr_onehot_arbiter
// PURPOSE
// - Round-robin arbiter sharing one resource among NUM_REQ requesters; grant is a
//   registered one-hot vector plus its binary index (gnt_o == 1 << gnt_idx_o).
// - Sits in front of the shared datapath. It feeds the binary-to-one-hot select
//   path and holds each grant until the owner signals done_i.
// PARAMETERS
// - NUM_REQ      16   number of requesters; must equal 2**IDX_W
// - IDX_W        4    width of the binary grant index
// - TIMEOUT_CYC  64   max grant length in cycles; used only with ARB_TIMEOUT_EN
// PORTS
// - clk          in   1        single clock, rising edge
// - rst_n        in   1        asynchronous, active-low reset
// - req_i        in   NUM_REQ  request vector; bit k = requester k
// - done_i       in   1        current owner releases the resource (1-cycle pulse)
// - gnt_o        out  NUM_REQ  one-hot grant; all zero when idle
// - gnt_idx_o    out  IDX_W    binary index of the granted requester
// - gnt_valid_o  out  1        a grant is active
// - timeout_o    out  1        1-cycle pulse on forced release
// BEHAVIOUR
// - Reset: state=IDLE, gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, timeout_o=0, ptr=0.
//   Reset is asynchronous and takes effect mid-grant with no done_i required.
// - FSM has two states: IDLE and GRANT.
// - IDLE, req_i==0: stay in IDLE; outputs hold their reset values.
// - IDLE, req_i!=0: select the first set bit scanning ptr, ptr+1, ... modulo NUM_REQ.
//   - Next edge: GRANT, gnt_idx_o=winner, gnt_o=1<<winner, gnt_valid_o=1.
//   - Latency is 1 cycle from req sampled to grant visible.
// - GRANT: grant is sticky. Deasserting req_i does not drop it, and other
//   requests are ignored.
// - GRANT, done_i=1: next edge goes to IDLE, gnt_o=0, gnt_valid_o=0.
//   - ptr = gnt_idx_o+1, wrapping NUM_REQ-1 -> 0.
//   - gnt_idx_o keeps its last value.
//   - Minimum 1 idle cycle between consecutive grants.
// - done_i while in IDLE is ignored.
// - Pointer wrap: with ptr=NUM_REQ-1 and only req[0] set, req[0] wins.
// - Fairness: with all requests held high, the grant order is
//   ptr, ptr+1, ..., and each requester is served once per NUM_REQ grants.
// - Invariant: gnt_o is one-hot or zero, and gnt_valid_o == |gnt_o.
// CONFIGURATION
// - Macro ARB_TIMEOUT_EN selects the watchdog.
// - ARB_TIMEOUT_EN defined:
//   - A counter clears on entry to GRANT and increments each GRANT cycle.
//   - If it reaches TIMEOUT_CYC-1 with done_i=0, the next edge goes to IDLE,
//     ptr advances as for done_i, and timeout_o pulses for 1 cycle.
//   - done_i in the same cycle as the timeout: treated as a normal release,
//     timeout_o=0.
// - ARB_TIMEOUT_EN undefined: no counter is built; timeout_o is tied to 0 and
//   a grant is held indefinitely until done_i.
// TESTING
// - Reset release, req_i=0 for 10 cycles -> gnt_o=0, gnt_valid_o=0, timeout_o=0.
// - req_i=16'h0010 -> 1 cycle later gnt_o=16'h0010, gnt_idx_o=4.
//   done_i pulse -> IDLE next edge, ptr=5.
// - req_i=16'hFFFF held, done_i pulsed on every grant -> gnt_idx_o sequence
//   0,1,...,15,0 with one idle cycle between grants.
// - After a grant to 15, req_i=16'h0001 -> gnt_idx_o=0 (wrap).
//   req_i=16'h0009 with ptr=1 -> gnt_idx_o=3.
// - Grant to 2, then req_i dropped to 0 without done_i -> gnt_o stays 16'h0004.
//   rst_n asserted mid-grant -> all outputs 0 immediately.
// - With ARB_TIMEOUT_EN, TIMEOUT_CYC=8, grant held with no done_i -> release
//   after 8 GRANT cycles, timeout_o pulses once, next requester is granted.
// - Without ARB_TIMEOUT_EN, the same stimulus -> grant held for 100 cycles,
//   timeout_o stays 0.

Source files
------------

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a sticky, registered one-hot grant and its binary index.
// A grant is held until the owner pulses done_i. The rotating priority pointer then
// moves just past the last owner.
// Optional watchdog: define ARB_TIMEOUT_EN to force a release after TIMEOUT_CYC
// grant cycles. Without it, timeout_o is tied low.
module rr_onehot_arbiter #(
    parameter int unsigned NUM_REQ     = 16,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               done_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o,
    output logic               timeout_o
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               to_q, to_d;

    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic               win_found;
    logic               expire;

    // Rotating priority scan: the descending loop leaves the lowest offset from ptr as winner.
    // The index arithmetic wraps naturally because NUM_REQ == 2**IDX_W.
    always_comb begin
        win_idx   = ptr_q;
        win_found = 1'b0;
        cand      = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            cand = ptr_q + IDX_W'(i);
            if (req_i[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Grant-length counter: held at zero while idle, so it starts from zero on grant entry.
    always_comb begin
        cnt_d = '0;
        if (state_q == StGrant) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Grant-length counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (state_q == StGrant) && (cnt_q == CntW'(TIMEOUT_CYC - 1));
`else
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = TIMEOUT_CYC;
    assign expire             = 1'b0;
`endif

    // Next-state logic: grant on any request from idle, release on done_i or watchdog expiry.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        to_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StGrant;
                    idx_d   = win_idx;
                    gnt_d   = NUM_REQ'(1) << win_idx;
                end
            end
            StGrant: begin
                if (done_i || expire) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    ptr_d   = idx_q + IDX_W'(1);
                    // done_i in the expiry cycle counts as a normal release.
                    to_d    = !done_i;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers. The index keeps its last value across idle periods.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            to_q    <= to_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = (state_q == StGrant);
    assign timeout_o   = to_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter: a behavioural round-robin model is compared
// against the DUT every cycle, alongside directed scenarios with literal expectations.
// The model follows ARB_TIMEOUT_EN when it is defined.
module tb_rr_onehot_arbiter;

    localparam int N = 16;
`ifdef ARB_TIMEOUT_EN
    localparam int TB_TO = 8;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TB_TO = 64;
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] req_i = '0;
    logic         done_i = 1'b0;
    logic [N-1:0] gnt_o;
    logic [3:0]   gnt_idx_o;
    logic         gnt_valid_o;
    logic         timeout_o;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    rr_onehot_arbiter #(
        .NUM_REQ    (N),
        .IDX_W      (4),
        .TIMEOUT_CYC(TB_TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .done_i     (done_i),
        .gnt_o      (gnt_o),
        .gnt_idx_o  (gnt_idx_o),
        .gnt_valid_o(gnt_valid_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: first requester at or after ptr (mod N) wins; grants are sticky.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    bit m_busy = 1'b0;
    int m_idx = 0;
    int m_ptr = 0;
    int m_cyc = 0;
    bit m_to = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_idx  <= 0;
            m_ptr  <= 0;
            m_cyc  <= 0;
            m_to   <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (!m_busy) begin
                if (pick(req_i, m_ptr) >= 0) begin
                    m_busy <= 1'b1;
                    m_idx  <= pick(req_i, m_ptr);
                    m_cyc  <= 0;
                end
            end else if (done_i) begin
                m_busy <= 1'b0;
                m_ptr  <= (m_idx + 1) % N;
            end else if (TO_EN && m_cyc == TB_TO - 1) begin
                m_busy <= 1'b0;
                m_ptr  <= (m_idx + 1) % N;
                m_to   <= 1'b1;
            end else begin
                m_cyc <= m_cyc + 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_gnt", 32'(gnt_o), m_busy ? (32'd1 << m_idx) : 32'd0);
            check("cmp_idx", 32'(gnt_idx_o), 32'(m_idx));
            check("cmp_valid", 32'(gnt_valid_o), 32'(m_busy));
            check("cmp_timeout", 32'(timeout_o), 32'(m_to));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        req_i  = '0;
        done_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int max_cyc);
        int n = 0;
        while (!gnt_valid_o && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (!gnt_valid_o) check("grant_wait_expired", 32'(gnt_valid_o), 32'd1);
    endtask

    // Pulse done_i for one cycle; the release must be visible at the following negedge.
    task automatic pulse_done(input logic [N-1:0] next_req);
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        req_i  = next_req;
        check("release_idle", 32'(gnt_valid_o), 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        chk_en = 1'b1;

        // Idle after reset.
        repeat (10) @(negedge clk);
        check("idle_gnt", 32'(gnt_o), 32'h0);
        check("idle_valid", 32'(gnt_valid_o), 32'd0);
        check("idle_timeout", 32'(timeout_o), 32'd0);

        // Single request, then pointer moves to 5.
        req_i = 16'h0010;
        @(negedge clk);
        check("single_gnt", 32'(gnt_o), 32'h0010);
        check("single_idx", 32'(gnt_idx_o), 32'd4);
        pulse_done(16'h0021);
        check("idx_kept", 32'(gnt_idx_o), 32'd4);
        @(negedge clk);
        check("ptr5_idx", 32'(gnt_idx_o), 32'd5);
        pulse_done(16'h0000);

        // Fairness with all requesters active.
        do_reset();
        req_i = 16'hFFFF;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            wait_grant(4);
            check("rr_seq", 32'(gnt_idx_o), 32'(k));
            pulse_done((k == N - 1) ? 16'h0001 : 16'hFFFF);
            @(negedge clk);
        end
        check("wrap_idx", 32'(gnt_idx_o), 32'd0);
        pulse_done(16'h0009);
        @(negedge clk);
        check("ptr1_idx", 32'(gnt_idx_o), 32'd3);
        pulse_done(16'h0000);

        // Sticky grant, then asynchronous reset mid-grant.
        req_i = 16'h0004;
        @(negedge clk);
        req_i = 16'h0000;
        repeat (5) begin
            @(negedge clk);
            check("sticky_gnt", 32'(gnt_o), 32'h0004);
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_gnt", 32'(gnt_o), 32'h0);
        check("async_valid", 32'(gnt_valid_o), 32'd0);
        check("async_idx", 32'(gnt_idx_o), 32'd0);
        check("async_timeout", 32'(timeout_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Long hold without done_i.
        do_reset();
        req_i = 16'h0003;
        @(negedge clk);
        check("hold_idx", 32'(gnt_idx_o), 32'd0);
`ifdef ARB_TIMEOUT_EN
        repeat (TB_TO - 1) begin
            @(negedge clk);
            check("hold_valid", 32'(gnt_valid_o), 32'd1);
        end
        @(negedge clk);
        check("to_valid", 32'(gnt_valid_o), 32'd0);
        check("to_pulse", 32'(timeout_o), 32'd1);
        @(negedge clk);
        check("to_next_idx", 32'(gnt_idx_o), 32'd1);
        check("to_once", 32'(timeout_o), 32'd0);
`else
        repeat (100) begin
            @(negedge clk);
            check("hold_valid", 32'(gnt_valid_o), 32'd1);
            check("hold_timeout", 32'(timeout_o), 32'd0);
        end
`endif
        pulse_done(16'h0000);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0: req_i = '0;
                    1: req_i = N'(1) << $urandom_range(0, N - 1);
                    2: req_i = N'($urandom);
                    default: req_i = N'($urandom) & N'($urandom);
                endcase
            end
            done_i = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        done_i = 1'b0;
        req_i  = '0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
